alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
Shares the single 8-bit signed ALU between two requesters (r0, r1) using round-robin arbitration. It accepts one operation at a time over a valid/ready handshake, issues it to the ALU with a one-cycle start pulse, and waits for the ALU done pulse. It then returns the signed 8-bit result and its 3-bit data type over a valid/ready response channel tagged with the requester ID. It sits between the operation sources and the ALU, inside the top-level wrapper.

Parameters:
TIMEOUT, 16, maximum number of WAIT cycles for alu_done before an error response is returned (must be ≥2).
ERR_TYPE, 3'd7, rsp_type code returned on timeout. The ALU never produces this code.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
r0_valid  in  1  requester 0 has an operation
r0_ready  out  1  requester 0 operation accepted this cycle
r0_op  in  3  requester 0 opcode
r0_a  in  8  requester 0 operand A, signed
r0_b  in  8  requester 0 operand B, signed
r1_valid, r1_ready, r1_op, r1_a, r1_b  same as r0, for requester 1
alu_start  out  1  one-cycle issue pulse to the ALU
alu_op  out  3  opcode to the ALU
alu_a  out  8  operand A to the ALU, signed
alu_b  out  8  operand B to the ALU, signed
alu_done  in  1  ALU result valid, one-cycle pulse
alu_result  in  8  ALU result, signed
alu_type  in  3  ALU result data type
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_id  out  1  requester that owns the response
rsp_data  out  8  result, signed
rsp_type  out  3  result data type, or ERR_TYPE on timeout
stray_done  out  1  sticky flag: alu_done seen outside WAIT

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything else and may abort any state. After reset:
  - state=IDLE, last_grant=1 (so r0 wins the first tie), count=0.
  - alu_start=0; alu_op, alu_a, alu_b = 0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_type=0, stray_done=0.
  - A response pending at reset time is dropped.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = r0 if only r0_valid; r1 if only r1_valid; if both valid, the requester != last_grant.
  - rX_ready = (state==IDLE) && rX_valid && grant==X. This is combinational, and at most one ready is high in a cycle.
  - On the handshake: latch op, a and b into alu_op/alu_a/alu_b; set rsp_id=grant and last_grant=grant; go to ISSUE.
  - No valid inputs: stay in IDLE.
- ISSUE: alu_start=1 for exactly this cycle; count<=0; go to WAIT. alu_op/a/b hold their values until the next accept.
- WAIT:
  - If alu_done: rsp_data<=alu_result, rsp_type<=alu_type, go to RESP.
  - Else, if count==TIMEOUT-1: rsp_data<=0, rsp_type<=ERR_TYPE, go to RESP.
  - Else: count<=count+1.
  - alu_done takes priority over the timeout when both occur in the same cycle.
- RESP:
  - rsp_valid=1. rsp_id, rsp_data and rsp_type stay stable while rsp_ready=0.
  - On rsp_ready: go to IDLE. rsp_valid is low in the next cycle.
  - No request is accepted during RESP. Minimum issue-to-issue spacing is 4 cycles.
- Latency: request accept to alu_start is 1 cycle. alu_done to rsp_valid is 1 cycle.
- Any alu_done in IDLE, ISSUE or RESP is ignored for data and sets stray_done=1. stray_done clears only on rst.
- Requesters must hold valid/op/a/b until ready. Deasserting valid before grant simply withdraws the request.
- Operands and result pass through unmodified as 8-bit two's complement. No arithmetic is done in this block.

Test Plan:
- Single request: r0 sends op=3'd0, a=8'sd5, b=-8'sd3. ALU done 2 cycles after start with result 2, type 1. Expect:
  - alu_start exactly 1 cycle after r0_ready.
  - rsp_valid with id=0, data=2, type=1, one cycle after done.
- Tie: r0 and r1 both valid continuously for 4 transactions, rsp_ready=1, ALU latency 1. Expect grant order r0,r1,r0,r1 and rsp_id sequence 0,1,0,1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid while r1 is valid. Expect:
  - rsp_data/type/id stable throughout.
  - r1_ready stays low until the cycle after rsp_ready=1 completes the handshake.
- Timeout: the ALU never asserts done with TIMEOUT=16. Expect rsp_valid 17 cycles after alu_start, with data=0, type=3'd7.
- Done coincides with the last timeout cycle (count==15). Expect the ALU result returned, not ERR_TYPE.
- Reset and stray done:
  - Assert rst during WAIT. Expect IDLE, all outputs 0, and r0 granted first afterwards.
  - Pulse alu_done in IDLE. Expect stray_done=1 from the next cycle, with no response generated.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. It accepts one op,
// issues it with a start pulse, waits for done (or times out) and returns a tagged response.
module alu_req_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [2:0]  ERR_TYPE = 3'd7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [2:0]        r0_op,
  input  logic signed [7:0] r0_a,
  input  logic signed [7:0] r0_b,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [2:0]        r1_op,
  input  logic signed [7:0] r1_a,
  input  logic signed [7:0] r1_b,
  output logic              alu_start,
  output logic [2:0]        alu_op,
  output logic signed [7:0] alu_a,
  output logic signed [7:0] alu_b,
  input  logic              alu_done,
  input  logic signed [7:0] alu_result,
  input  logic [2:0]        alu_type,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic signed [7:0] rsp_data,
  output logic [2:0]        rsp_type,
  output logic              stray_done,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
  // valid must not depend on ready, and the source holds its payload stable until the transfer.

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic signed [7:0] alu_a_q, alu_a_d;
  logic signed [7:0] alu_b_q, alu_b_d;
  logic              rsp_id_q, rsp_id_d;
  logic signed [7:0] rsp_data_q, rsp_data_d;
  logic [2:0]        rsp_type_q, rsp_type_d;
  logic              stray_q, stray_d;
  logic              grant;

  // On a tie the requester that did not win last time gets the slot.
  assign grant    = (r0_valid && r1_valid) ? ~last_grant_q : r1_valid;
  assign r0_ready = (state_q == IDLE) && r0_valid && !grant;
  assign r1_ready = (state_q == IDLE) && r1_valid && grant;

  assign alu_start  = (state_q == ISSUE);
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_type   = rsp_type_q;
  assign stray_done = stray_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_type_d   = rsp_type_q;
    stray_d      = stray_q;

    // A done pulse outside WAIT has no owner; flag it and drop its data.
    if (alu_done && (state_q != WAIT)) stray_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (r0_ready || r1_ready) begin
          alu_op_d     = grant ? r1_op : r0_op;
          alu_a_d      = grant ? r1_a  : r0_a;
          alu_b_d      = grant ? r1_b  : r0_b;
          rsp_id_d     = grant;
          last_grant_d = grant;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        count_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (alu_done) begin
          rsp_data_d = alu_result;
          rsp_type_d = alu_type;
          state_d    = RESP;
        end else if (count_q == CW'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_type_d = ERR_TYPE;
          state_d    = RESP;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      count_q      <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_type_q   <= '0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_type_q   <= rsp_type_d;
      stray_q      <= stray_d;
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: reset, single op, round-robin ties,
// backpressure, timeout, done on the last wait cycle, reset in WAIT and stray done.
module tb_alu_req_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic              r0_valid, r0_ready;
  logic [2:0]        r0_op;
  logic signed [7:0] r0_a, r0_b;
  logic              r1_valid, r1_ready;
  logic [2:0]        r1_op;
  logic signed [7:0] r1_a, r1_b;
  logic              alu_start;
  logic [2:0]        alu_op;
  logic signed [7:0] alu_a, alu_b;
  logic              alu_done;
  logic signed [7:0] alu_result;
  logic [2:0]        alu_type;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic signed [7:0] rsp_data;
  logic [2:0]        rsp_type;
  logic              stray_done;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  alu_req_arbiter #(.TIMEOUT(16), .ERR_TYPE(3'd7)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_type(alu_type),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_type(rsp_type), .stray_done(stray_done),
    .dbg_state(dbg_state)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},     {6'd0, dbg_state}, 8'd0);
    check({tag, "_start"},     {7'd0, alu_start}, 8'd0);
    check({tag, "_op"},        {5'd0, alu_op}, 8'd0);
    check({tag, "_a"},         alu_a, 8'd0);
    check({tag, "_b"},         alu_b, 8'd0);
    check({tag, "_rsp_valid"}, {7'd0, rsp_valid}, 8'd0);
    check({tag, "_rsp_id"},    {7'd0, rsp_id}, 8'd0);
    check({tag, "_rsp_data"},  rsp_data, 8'd0);
    check({tag, "_rsp_type"},  {5'd0, rsp_type}, 8'd0);
    check({tag, "_stray"},     {7'd0, stray_done}, 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    r0_valid = 1'b0; r0_op = 3'd0; r0_a = 8'sd0; r0_b = 8'sd0;
    r1_valid = 1'b0; r1_op = 3'd0; r1_a = 8'sd0; r1_b = 8'sd0;
    alu_done = 1'b0; alu_result = 8'sd0; alu_type = 3'd0;
    rsp_ready = 1'b0;
    tick(); tick();
    check_reset_outputs("rst0");
    rst = 1'b0;
    check("rst0_r0_ready", {7'd0, r0_ready}, 8'd0);

    // Single request from r0, ALU done two cycles after start.
    r0_valid = 1'b1; r0_op = 3'd0; r0_a = 8'sd5; r0_b = -8'sd3;
    #0;
    check("single_r0_ready", {7'd0, r0_ready}, 8'd1);
    check("single_r1_ready", {7'd0, r1_ready}, 8'd0);
    tick();
    r0_valid = 1'b0;
    check("single_start", {7'd0, alu_start}, 8'd1);
    check("single_op", {5'd0, alu_op}, 8'd0);
    check("single_a", alu_a, 8'h05);
    check("single_b", alu_b, 8'hFD);
    tick();
    check("single_start_pulse", {7'd0, alu_start}, 8'd0);
    tick();
    alu_done = 1'b1; alu_result = 8'sd2; alu_type = 3'd1;
    tick();
    alu_done = 1'b0;
    check("single_rsp_valid", {7'd0, rsp_valid}, 8'd1);
    check("single_rsp_id", {7'd0, rsp_id}, 8'd0);
    check("single_rsp_data", rsp_data, 8'd2);
    check("single_rsp_type", {5'd0, rsp_type}, 8'd1);
    rsp_ready = 1'b1;
    tick();
    check("single_rsp_drop", {7'd0, rsp_valid}, 8'd0);

    // Reset so the tie sequence starts with r0.
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Tie: both valid, ALU latency 1, expect r0,r1,r0,r1.
    r0_valid = 1'b1; r0_op = 3'd2; r0_a = 8'sd10; r0_b = 8'sd1;
    r1_valid = 1'b1; r1_op = 3'd3; r1_a = 8'sd20; r1_b = 8'sd2;
    for (int i = 0; i < 4; i++) begin
      #0;
      check($sformatf("tie%0d_r0_ready", i), {7'd0, r0_ready}, (i % 2 == 0) ? 8'd1 : 8'd0);
      check($sformatf("tie%0d_r1_ready", i), {7'd0, r1_ready}, (i % 2 == 1) ? 8'd1 : 8'd0);
      tick();
      check($sformatf("tie%0d_start", i), {7'd0, alu_start}, 8'd1);
      check($sformatf("tie%0d_a", i), alu_a, (i % 2 == 0) ? 8'd10 : 8'd20);
      tick();
      alu_done = 1'b1; alu_result = 8'(i); alu_type = 3'd4;
      tick();
      alu_done = 1'b0;
      check($sformatf("tie%0d_rsp_valid", i), {7'd0, rsp_valid}, 8'd1);
      check($sformatf("tie%0d_rsp_id", i), {7'd0, rsp_id}, (i % 2 == 0) ? 8'd0 : 8'd1);
      check($sformatf("tie%0d_rsp_data", i), rsp_data, 8'(i));
      tick();
    end

    // Backpressure: r0 wins (last grant was r1), r1 stays valid throughout.
    rsp_ready = 1'b0;
    r0_op = 3'd1; r0_a = -8'sd4; r0_b = -8'sd3;
    #0;
    check("bp_r0_ready", {7'd0, r0_ready}, 8'd1);
    tick();
    r0_valid = 1'b0;
    tick();
    alu_done = 1'b1; alu_result = -8'sd7; alu_type = 3'd2;
    tick();
    alu_done = 1'b0; alu_result = 8'sd0; alu_type = 3'd0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_valid", i), {7'd0, rsp_valid}, 8'd1);
      check($sformatf("bp%0d_data", i), rsp_data, 8'hF9);
      check($sformatf("bp%0d_type", i), {5'd0, rsp_type}, 8'd2);
      check($sformatf("bp%0d_id", i), {7'd0, rsp_id}, 8'd0);
      check($sformatf("bp%0d_r1_ready", i), {7'd0, r1_ready}, 8'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #0;
    check("bp_r1_ready_in_resp", {7'd0, r1_ready}, 8'd0);
    tick();
    check("bp_rsp_dropped", {7'd0, rsp_valid}, 8'd0);
    check("bp_r1_ready_after", {7'd0, r1_ready}, 8'd1);

    // Timeout on r1's op: the ALU never answers.
    tick();
    r1_valid = 1'b0;
    check("to_start", {7'd0, alu_start}, 8'd1);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check("to_latency", 8'(n), 8'd17);
    check("to_data", rsp_data, 8'd0);
    check("to_type", {5'd0, rsp_type}, 8'd7);
    check("to_id", {7'd0, rsp_id}, 8'd1);
    tick();

    // Done arrives on the last wait cycle (count==15): result wins over timeout.
    r0_valid = 1'b1; r0_op = 3'd5; r0_a = 8'sd1; r0_b = 8'sd2;
    #0;
    check("edge_r0_ready", {7'd0, r0_ready}, 8'd1);
    tick();
    r0_valid = 1'b0;
    check("edge_start", {7'd0, alu_start}, 8'd1);
    for (int i = 0; i < 16; i++) tick();
    check("edge_no_rsp_yet", {7'd0, rsp_valid}, 8'd0);
    alu_done = 1'b1; alu_result = 8'sh55; alu_type = 3'd3;
    tick();
    alu_done = 1'b0;
    check("edge_rsp_valid", {7'd0, rsp_valid}, 8'd1);
    check("edge_rsp_data", rsp_data, 8'h55);
    check("edge_rsp_type", {5'd0, rsp_type}, 8'd3);
    check("edge_stray", {7'd0, stray_done}, 8'd0);
    tick();

    // Reset while waiting on the ALU.
    r1_valid = 1'b1; r1_op = 3'd6; r1_a = 8'sd9; r1_b = 8'sd9;
    #0;
    check("rstw_r1_ready", {7'd0, r1_ready}, 8'd1);
    tick();
    r1_valid = 1'b0;
    tick();
    check("rstw_in_wait", {6'd0, dbg_state}, 8'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rstw");
    r0_valid = 1'b1; r1_valid = 1'b1;
    #0;
    check("rstw_r0_first", {7'd0, r0_ready}, 8'd1);
    check("rstw_r1_not", {7'd0, r1_ready}, 8'd0);
    r0_valid = 1'b0; r1_valid = 1'b0;

    // Stray done in IDLE.
    alu_done = 1'b1; alu_result = 8'sd33; alu_type = 3'd5;
    tick();
    alu_done = 1'b0;
    check("stray_set", {7'd0, stray_done}, 8'd1);
    check("stray_no_rsp", {7'd0, rsp_valid}, 8'd0);
    check("stray_idle", {6'd0, dbg_state}, 8'd0);
    tick();
    check("stray_sticky", {7'd0, stray_done}, 8'd1);
    check("stray_no_rsp2", {7'd0, rsp_valid}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
